limbus_nios_oci_dct_packer: RTL
===============================

# limbus_nios_oci_dct_packer

Producer side of the Nios OCI trace-capture path. Accepts a stream of 3-bit trace atoms and packs them LSB-first into 30-bit frames. Presents each frame as `dct_buffer` plus a slot count `dct_count` to the OCI trace sink under a valid/ready handshake. Also owns end-of-test sequencing: on `test_ending` it flushes any partial frame, then raises `test_has_ended`.

## Interface
- `ATOM_W`, 3: width of one trace atom.
- `SLOTS`, 10: atoms per frame; `ATOM_W*SLOTS` must equal 30.
- `IDLE_FLUSH`, 64: idle cycles with a non-empty accumulator before a partial frame is forced out; 0 disables the timeout.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `atom_valid` in 1: upstream atom present.
- `atom_data` in 3: trace atom.
- `atom_ready` out 1: packer accepts the atom this cycle.
- `test_ending` in 1: level or pulse; requests final flush.
- `dct_buffer` out 30: packed frame; slot k occupies bits [3k+2:3k].
- `dct_count` out 4: valid slots in `dct_buffer`, 1..10.
- `dct_valid` out 1: frame held on `dct_buffer`/`dct_count`.
- `dct_ready` in 1: sink takes the frame.
- `test_has_ended` out 1: sticky; all trace delivered after `test_ending`.

## Operation
- Two storage stages:
  - accumulator: `acc_buf[29:0]`, `acc_cnt` 0..10.
  - output register: `dct_buffer`, `dct_count`, `dct_valid`.
- Atom accept:
  - Condition: `atom_valid && atom_ready`.
  - Effect: `atom_data` written to slot `acc_cnt`; `acc_cnt` increments.
- Transfer from accumulator to output register happens when the output register is free, meaning `!dct_valid || dct_ready`, and one of:
  - the accumulator becomes or is full (10);
  - the idle timer expires;
  - a flush is pending.
- On transfer:
  - Accumulator is cleared.
  - Unused slots in the frame are zero.
  - A count of 0 is never emitted.
- Full-frame fast path: the 10th atom is accepted and the output register is free → that frame loads directly on the same edge.
- `atom_ready = (state==RUN) && (acc_cnt<10 || output register free)`.
  - If the accumulator is full and transfers this cycle, a new atom in the same cycle goes to slot 0 of the fresh accumulator.
- Idle timer:
  - Counts cycles with `acc_cnt!=0` and no accept.
  - Reset by any accept or any transfer.
  - Expiry at `IDLE_FLUSH` requests a flush.
  - The flush stays pending until the transfer is possible.
- State machine:
  - RUN:
    - Normal packing.
    - `test_ending` seen → DRAIN; `atom_ready` drops the next cycle.
    - An atom accepted in the same cycle as `test_ending` is kept and flushed.
  - DRAIN:
    - Any partial accumulator is force-transferred.
    - Go to DONE when the accumulator is empty and the output register is empty, or is being consumed this cycle.
  - DONE:
    - `test_has_ended`=1, `atom_ready`=0.
    - Held until `reset`; further `test_ending` is ignored.
- `dct_buffer` and `dct_count` are stable while `dct_valid && !dct_ready`.

## Timing
- Reset values:
  - `dct_valid`=0, `dct_buffer`=0, `dct_count`=0.
  - `atom_ready`=0 during the reset cycle, 1 on the first cycle after.
  - `test_has_ended`=0; state RUN; accumulator and idle timer 0.
- Reset mid-operation discards all frames, held or partial, without emitting them.
- Latency, 10th atom accepted at cycle N with output register free → `dct_valid`=1 at N+1.
- Latency, idle flush: last accept at N → `dct_valid` at N+`IDLE_FLUSH`+1, given a free output register.
- `test_ending` at N:
  - State = DRAIN at N+1.
  - Partial frame valid at N+2 at the earliest.
  - `test_has_ended` rises the cycle after the final handshake completes.
- `test_ending` with nothing buffered: `test_has_ended`=1 at N+2.
- Throughput: one atom per cycle sustained when `dct_ready` is held high.

## Structure
- Shared package `limbus_nios_oci_pkg` holds:
  - `DCT_BUF_W`=30, `DCT_CNT_W`=4, `DCT_SLOTS`=10;
  - the state enum {RUN, DRAIN, DONE}.
- One natural sub-module: `limbus_nios_oci_dct_idle_timer`, the idle counter with clear and expire outputs.

## Test plan
- Packing order:
  - Stimulus: atoms 1..7 then 0,1,2 back-to-back, `dct_ready`=1.
  - Required: one frame, `dct_count`=10; `dct_buffer[2:0]`=1, `[20:18]`=7, `[29:27]`=2.
  - `atom_ready` never drops.
- Backpressure:
  - Stimulus: 25 atoms, `dct_ready`=0 for 40 cycles.
  - Required: `atom_ready` low after 20 atoms accepted.
  - Frame 1 is held stable throughout.
  - Release → frames 1 and 2 (count 10 each) delivered; remaining 5 atoms accepted.
- Idle flush:
  - Stimulus: 4 atoms of value 5, then idle.
  - Required: frame with count 4 and `dct_buffer`=30'o5555 at exactly 65 cycles after the last accept.
- End of test:
  - Stimulus: 13 atoms, then `test_ending` pulse.
  - Required: frames of count 10 and count 3.
  - `test_has_ended` rises one cycle after the second handshake.
  - `atom_ready` stays 0 thereafter.
- Reset mid-frame:
  - Stimulus: 6 atoms, then `reset` for 1 cycle with `dct_ready`=1.
  - Required: no frame emitted; all outputs at reset values.
  - Next 10 atoms produce a single clean frame with count 10.

Source files
------------

// File: rtl/limbus_nios_oci_pkg.sv
// Shared constants and state encoding for the Nios OCI trace-capture path.
package limbus_nios_oci_pkg;
  localparam int unsigned DCT_BUF_W = 30;
  localparam int unsigned DCT_CNT_W = 4;
  localparam int unsigned DCT_SLOTS = 10;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/limbus_nios_oci_dct_idle_timer.sv
// Counts idle cycles while the accumulator holds atoms; pulses expire on the LIMIT-th one.
module limbus_nios_oci_dct_idle_timer #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);
  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt;

  // LIMIT of 0 disables the timeout altogether.
  assign expire = (LIMIT != 0) && count && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || expire) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/limbus_nios_oci_dct_packer.sv
// Packs 3-bit trace atoms LSB-first into 30-bit frames for the OCI trace sink,
// and sequences the end-of-test flush.
module limbus_nios_oci_dct_packer
  import limbus_nios_oci_pkg::*;
#(
  parameter int unsigned ATOM_W     = 3,
  parameter int unsigned SLOTS      = DCT_SLOTS,
  parameter int unsigned IDLE_FLUSH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 atom_valid,
  input  logic [ATOM_W-1:0]    atom_data,
  output logic                 atom_ready,
  input  logic                 test_ending,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 dct_valid,
  input  logic                 dct_ready,
  output logic                 test_has_ended
);
  localparam logic [DCT_CNT_W-1:0] FULL = DCT_CNT_W'(SLOTS);

  state_t               state;
  logic [DCT_BUF_W-1:0] acc_buf;
  logic [DCT_BUF_W-1:0] frame_buf;
  logic [DCT_CNT_W-1:0] acc_cnt;
  logic [DCT_CNT_W-1:0] frame_cnt;
  logic                 flush_pend;
  logic                 out_free;
  logic                 acc_full;
  logic                 accept;
  logic                 want_xfer;
  logic                 transfer;
  logic                 expire;
  logic                 idle_inc;
  logic                 idle_clr;

  // frame_buf/frame_cnt is the accumulator including this cycle's atom, so a
  // 10th atom can load the output register on the same edge it is accepted.
  // A full accumulator stalled behind the sink is frame_buf unchanged; an atom
  // arriving as it drains goes to slot 0 of the fresh accumulator instead.
  always_comb begin
    out_free   = !dct_valid || dct_ready;
    acc_full   = (acc_cnt == FULL);
    atom_ready = !reset && (state == RUN) && (!acc_full || out_free);
    accept     = atom_valid && atom_ready;
    frame_buf  = acc_buf;
    frame_cnt  = acc_cnt;
    if (!acc_full && accept) begin
      for (int unsigned k = 0; k < SLOTS; k++) begin
        if (DCT_CNT_W'(k) == acc_cnt) begin
          frame_buf[k*ATOM_W +: ATOM_W] = atom_data;
        end
      end
      frame_cnt = acc_cnt + DCT_CNT_W'(1);
    end
    want_xfer = (frame_cnt == FULL) ||
                ((frame_cnt != '0) && (flush_pend || expire || (state == DRAIN)));
    transfer  = out_free && want_xfer;
    idle_inc  = (acc_cnt != '0) && !accept;
    idle_clr  = accept || transfer;
  end

  limbus_nios_oci_dct_idle_timer #(
    .LIMIT(IDLE_FLUSH)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (idle_clr),
    .count (idle_inc),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      acc_buf        <= '0;
      acc_cnt        <= '0;
      flush_pend     <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (transfer) begin
        dct_buffer <= frame_buf;
        dct_count  <= frame_cnt;
        dct_valid  <= 1'b1;
        flush_pend <= 1'b0;
        if (acc_full && accept) begin
          acc_buf <= DCT_BUF_W'(atom_data);
          acc_cnt <= DCT_CNT_W'(1);
        end else begin
          acc_buf <= '0;
          acc_cnt <= '0;
        end
      end else begin
        if (dct_ready) begin
          dct_valid <= 1'b0;
        end
        acc_buf <= frame_buf;
        acc_cnt <= frame_cnt;
        if (expire) begin
          flush_pend <= 1'b1;
        end
      end

      case (state)
        RUN: begin
          if (test_ending) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((acc_cnt == '0) && out_free) begin
            state          <= DONE;
            test_has_ended <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
